// File: rtl/pipe_stall_ctrl_if.sv
// Pipeline-controller bundle: hazard/memory inputs and register enables.
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             ex_memread;
    logic [4:0]       ex_rt;
    logic             ex_branch_taken;
    logic             mem_memread;
    logic             mem_memwrite;
    logic             dmem_ready;
    logic             dmem_req;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_bubble;
    logic             exmem_en;
    logic             memwb_en;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs, id_rt, ex_memread, ex_rt, ex_branch_taken,
        output mem_memread, mem_memwrite, dmem_ready,
        input  dmem_req, pc_en, ifid_en, ifid_flush, idex_en,
        input  idex_bubble, exmem_en, memwb_en, mem_err, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, ex_memread, ex_rt, ex_branch_taken,
        input  mem_memread, mem_memwrite, dmem_ready,
        output dmem_req, pc_en, ifid_en, ifid_flush, idex_en,
        output idex_bubble, exmem_en, memwb_en, mem_err, stall_cycles
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Arbitrates memory wait, load-use hazard and branch flush.
module pipe_stall_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input logic               clock,
    input logic               reset,
    pipe_stall_ctrl_if.slave  bus
);
    typedef enum logic {
        S_RUN,
        S_WAIT
    } state_e;

    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic mem_op;
    logic load_use;
    logic mem_stall;
    logic req;
    logic pc_en, ifid_en, ifid_flush;
    logic idex_en, idex_bubble;
    logic exmem_en, memwb_en;

    assign mem_op   = bus.mem_memread | bus.mem_memwrite;
    assign load_use = bus.ex_memread && (bus.ex_rt != 5'd0) &&
                      ((bus.ex_rt == bus.id_rs) ||
                       (bus.ex_rt == bus.id_rt));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        stall_d     = stall_q;
        mem_stall   = 1'b0;
        req         = 1'b0;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_bubble = 1'b0;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;

        unique case (state_q)
            S_RUN: begin
                req = mem_op;
                if (mem_op && !bus.dmem_ready) begin
                    mem_stall = 1'b1;
                    state_d   = S_WAIT;
                    cnt_d     = 8'd0;
                end
            end
            S_WAIT: begin
                req = 1'b1;
                if (bus.dmem_ready) begin
                    state_d = S_RUN;
                end else if (cnt_q == TO_LAST) begin
                    // Abandon the access and let the pipeline move on.
                    err_d   = 1'b1;
                    state_d = S_RUN;
                end else begin
                    mem_stall = 1'b1;
                    cnt_d     = cnt_q + 8'd1;
                end
            end
            default: state_d = S_RUN;
        endcase

        if (mem_stall) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (bus.ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end

        if (!pc_en && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end

        if (reset) begin
            state_d     = S_RUN;
            cnt_d       = 8'd0;
            err_d       = 1'b0;
            stall_d     = '0;
            req         = 1'b0;
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_en     = 1'b0;
            idex_bubble = 1'b1;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        err_q   <= err_d;
        stall_q <= stall_d;
    end

    assign bus.dmem_req     = req;
    assign bus.pc_en        = pc_en;
    assign bus.ifid_en      = ifid_en;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_en      = idex_en;
    assign bus.idex_bubble  = idex_bubble;
    assign bus.exmem_en     = exmem_en;
    assign bus.memwb_en     = memwb_en;
    assign bus.mem_err      = err_q;
    assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: vector table plus multi-cycle sequences.
module tb_pipe_stall_ctrl;
    localparam int CNT_W = 4;
    localparam int TMO   = 4;

    // {req, pc, ifid_en, flush, idex_en, bubble, exmem, memwb}
    localparam logic [7:0] E_RUN = 8'b0110_1011;
    localparam logic [7:0] E_STL = 8'b1000_0000;
    localparam logic [7:0] E_REL = 8'b1110_1011;
    localparam logic [7:0] E_BR  = 8'b0111_1111;
    localparam logic [7:0] E_ALL = 8'b1111_1111;
    localparam logic [7:0] E_LU  = 8'b0000_1111;
    localparam logic [7:0] E_MLU = 8'b1000_1111;
    localparam logic [7:0] E_RST = 8'b0001_0100;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       exrd;
        logic [4:0] exrt;
        logic       br;
        logic       mrd;
        logic       mwr;
        logic       rdy;
        logic       rst;
        logic [7:0] exp;
        logic       err;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_stall_ctrl #(
        .MEM_TIMEOUT(TMO),
        .CNT_W(CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int idx   = 0;
    string tag = "init";
    logic [7:0] expq[$];
    logic [CNT_W-1:0] exp_stall = '0;

    function automatic vec_t mk(
        logic [4:0] rs, logic [4:0] rt, logic exrd, logic [4:0] exrt,
        logic br, logic mrd, logic mwr, logic rdy, logic rst,
        logic [7:0] exp, logic err);
        vec_t v;
        v.rs = rs; v.rt = rt; v.exrd = exrd; v.exrt = exrt;
        v.br = br; v.mrd = mrd; v.mwr = mwr; v.rdy = rdy;
        v.rst = rst; v.exp = exp; v.err = err;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        logic [7:0] got;
        logic [7:0] e;
        @(posedge clock);
        #1;
        reset               = v.rst;
        bus.id_rs           = v.rs;
        bus.id_rt           = v.rt;
        bus.ex_memread      = v.exrd;
        bus.ex_rt           = v.exrt;
        bus.ex_branch_taken = v.br;
        bus.mem_memread     = v.mrd;
        bus.mem_memwrite    = v.mwr;
        bus.dmem_ready      = v.rdy;
        expq.push_back(v.exp);
        @(negedge clock);
        got = {bus.dmem_req, bus.pc_en, bus.ifid_en, bus.ifid_flush,
               bus.idex_en, bus.idex_bubble, bus.exmem_en, bus.memwb_en};
        e = expq.pop_front();
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL %s[%0d] ctl got=%b want=%b", tag, idx, got, e);
        end
        if (!v.rst) begin
            tests++;
            if (bus.stall_cycles !== exp_stall) begin
                fails++;
                $display("FAIL %s[%0d] stall_cycles got=%0d want=%0d",
                         tag, idx, bus.stall_cycles, exp_stall);
            end
            tests++;
            if (bus.mem_err !== v.err) begin
                fails++;
                $display("FAIL %s[%0d] mem_err got=%b want=%b",
                         tag, idx, bus.mem_err, v.err);
            end
        end
        if (v.rst) exp_stall = '0;
        else if (!e[6] && exp_stall != '1) exp_stall = exp_stall + 1'b1;
        idx++;
    endtask

    task automatic seq(input string name);
        tag = name;
        idx = 0;
    endtask

    vec_t tbl[11];

    initial begin
        bus.id_rs = '0; bus.id_rt = '0; bus.ex_memread = 1'b0;
        bus.ex_rt = '0; bus.ex_branch_taken = 1'b0;
        bus.mem_memread = 1'b0; bus.mem_memwrite = 1'b0;
        bus.dmem_ready = 1'b0;

        seq("reset");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, E_RST, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, E_RST, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0));

        tbl[0]  = mk(1, 2, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0);
        tbl[1]  = mk(5, 7, 1, 5, 0, 0, 0, 0, 0, E_LU,  0);
        tbl[2]  = mk(5, 7, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0);
        tbl[3]  = mk(3, 9, 1, 9, 0, 0, 0, 0, 0, E_LU,  0);
        tbl[4]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, E_RUN, 0);
        tbl[5]  = mk(5, 5, 0, 5, 0, 0, 0, 0, 0, E_RUN, 0);
        tbl[6]  = mk(5, 7, 1, 5, 1, 0, 0, 0, 0, E_BR,  0);
        tbl[7]  = mk(1, 2, 0, 0, 1, 0, 0, 0, 0, E_BR,  0);
        tbl[8]  = mk(1, 2, 0, 0, 0, 1, 0, 1, 0, E_REL, 0);
        tbl[9]  = mk(1, 2, 0, 0, 1, 0, 1, 1, 0, E_ALL, 0);
        tbl[10] = mk(4, 6, 1, 6, 0, 1, 0, 1, 0, E_MLU, 0);
        seq("table");
        for (int i = 0; i < 11; i++) apply(tbl[i]);

        seq("rd_ready3");
        apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, E_STL, 0));
        apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, E_STL, 0));
        apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, E_STL, 0));
        apply(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, E_REL, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0));

        seq("ready_at_timeout");
        for (int i = 0; i < TMO; i++)
            apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, E_STL, 0));
        apply(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, E_REL, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0));

        seq("timeout");
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, E_STL, 0));
        for (int i = 1; i < TMO; i++)
            apply(mk(5, 7, 1, 5, 1, 0, 1, 0, 0, E_STL, 0));
        apply(mk(5, 7, 1, 5, 1, 0, 1, 0, 0, E_ALL, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 1));

        seq("saturate");
        for (int i = 0; i < 20; i++)
            apply(mk(8, 1, 1, 8, 0, 0, 0, 0, 0, E_LU, 1));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 1));

        seq("reset_in_wait");
        apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, E_STL, 1));
        apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, E_STL, 1));
        apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, E_RST, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0));
        apply(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, E_REL, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline controller for the 5-stage core.
- Drives the load enables and bubble/flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Arbitrates three stall sources: multi-cycle data-memory handshake, load-use hazard, and taken-branch flush.
- Keeps a sticky memory-timeout error flag and a saturating stall-cycle counter for debug.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles spent in WAIT before the access is abandoned; legal range 1..255.
- CNT_W, 16: width of the stall_cycles counter.

Ports:
- clock  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- ex_memread  in  1  the instruction in EX is a load.
- ex_rt  in  5  destination rt of the instruction in EX.
- ex_branch_taken  in  1  branch resolved taken in EX.
- mem_memread  in  1  the instruction in MEM is a load.
- mem_memwrite  in  1  the instruction in MEM is a store.
- dmem_ready  in  1  one-cycle completion pulse from data memory.
- dmem_req  out  1  data-memory access request.
- pc_en  out  1  PC load enable.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_en  out  1  ID/EX load enable.
- idex_bubble  out  1  ID/EX loads a NOP (all control bits zero).
- exmem_en  out  1  EX/MEM load enable.
- memwb_en  out  1  MEM/WB load enable.
- mem_err  out  1  sticky memory-timeout flag.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0.

Behaviour:
- Interface:
  - One clock, named clock.
  - Reset is synchronous and active-high, named reset.
- Reset:
  - State goes to RUN; the timeout counter, mem_err and stall_cycles clear at the next posedge.
  - While reset is high, the combinational outputs are forced: all *_en=0, ifid_flush=1, idex_bubble=1, dmem_req=0.
- Output timing:
  - FSM state, timeout counter, mem_err and stall_cycles are registered.
  - All other outputs are combinational from the current state and inputs (zero latency).
- Memory operation: mem_op = mem_memread | mem_memwrite.
- FSM states: RUN, WAIT.
- RUN:
  - dmem_req = mem_op.
  - If mem_op=1 and dmem_ready=0: memory stall this cycle, all five enables 0, next state WAIT, timeout counter cleared to 0.
  - If mem_op=1 and dmem_ready=1: access completes with no stall.
- WAIT:
  - dmem_req=1 held.
  - While dmem_ready=0 and counter < MEM_TIMEOUT-1: all enables 0, counter increments.
  - On dmem_ready=1: all enables 1, next state RUN.
  - On timeout (counter = MEM_TIMEOUT-1 with dmem_ready=0): mem_err<=1, all enables 1, next state RUN, so the access is abandoned and the pipeline advances.
  - dmem_ready and timeout in the same cycle: counts as a normal completion; mem_err is not set.
- Priority when no memory stall (RUN completing or idle), highest first:
  1. Branch flush (ex_branch_taken=1): all enables 1, ifid_flush=1, idex_bubble=1. Any load-use hazard in the same cycle is ignored, because the ID instruction is discarded.
  2. Load-use hazard (ex_memread=1, ex_rt≠0, and ex_rt==id_rs or ex_rt==id_rt): pc_en=0, ifid_en=0, idex_en=1, idex_bubble=1; exmem_en=1, memwb_en=1. Lasts exactly one cycle, because the bubble clears ex_memread.
  3. Otherwise: all enables 1, flush and bubble 0.
- A memory stall overrides both branch and load-use. ifid_flush and idex_bubble are 0 while the enables are 0, and the branch or hazard is re-evaluated on the cycle the stall releases.
- stall_cycles:
  - Increments on every non-reset cycle with pc_en=0.
  - Saturates at all-ones.
- mem_err clears only on reset.
- A reset asserted while in WAIT returns the FSM to RUN; dmem_req drops in the reset cycle.

Test Plan:
- Reset held 2 cycles, then released with idle inputs -> during reset all *_en=0, ifid_flush=1, idex_bubble=1; after release all *_en=1, stall_cycles=0, mem_err=0.
- mem_memread=1 with dmem_ready pulsed 3 cycles later -> dmem_req=1 for 4 cycles; enables 0 for 3 cycles, 1 on the ready cycle; stall_cycles=3.
- ex_memread=1, ex_rt=5, id_rs=5 -> exactly one cycle with pc_en=0, ifid_en=0, idex_bubble=1; repeat with ex_rt=0 -> no stall.
- ex_branch_taken=1 together with a load-use match -> ifid_flush=1, idex_bubble=1, pc_en=1.
- MEM_TIMEOUT=4, mem_memwrite=1 with dmem_ready never asserted -> enables 0 for 4 cycles, then mem_err=1 and enables 1; a branch during the stall is applied only on the release cycle.
- Reset asserted during the second WAIT cycle -> dmem_req=0 in the reset cycle; after release state is RUN and mem_err=0.
